// File: rtl/xpb_accum_seq_pkg.sv
// Shared types and constants for the xpb accumulator and the xpb tables feeding it.
// Holds the FSM state encoding and the window-counter width derivation.
`timescale 1ns/1ps
package xpb_accum_seq_pkg;

  localparam int WIN_BITS    = 5;
  localparam int DATA_W      = 1024;
  localparam int NUM_WIN_DEF = 8;
  localparam int GUARD_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A single-window configuration still needs a one-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xpb_accum_seq_if.sv
// Operand, table-lookup and result handshake bundle for xpb_accum_seq.
// master = upstream/parent logic (operand source, table mux, result sink); slave = accumulator.
`timescale 1ns/1ps
interface xpb_accum_seq_if
  import xpb_accum_seq_pkg::*;
#(
  parameter int NUM_WIN = NUM_WIN_DEF,
  parameter int GUARD   = GUARD_DEF
) ();
  localparam int CNT_W = cnt_w(NUM_WIN);

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_WIN*WIN_BITS-1:0] in_upper;
  logic [DATA_W-1:0]           in_lower;
  logic [CNT_W-1:0]            xpb_win;
  logic [WIN_BITS-1:0]         xpb_sel;
  logic [DATA_W-1:0]           xpb_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W+GUARD-1:0]     out_sum;
  logic                        busy;

  modport master (
    output in_valid, in_upper, in_lower, xpb_data, out_ready,
    input  in_ready, xpb_win, xpb_sel, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_upper, in_lower, xpb_data, out_ready,
    output in_ready, xpb_win, xpb_sel, out_valid, out_sum, busy
  );

endinterface

// File: rtl/xpb_accum_seq_win_mux.sv
// NUM_WIN-way mux of the xpb table outputs onto xpb_data, steered by xpb_win.
// Purely combinational; lives at the parent level alongside the tables.
`timescale 1ns/1ps
module xpb_win_mux
  import xpb_accum_seq_pkg::*;
#(
  parameter int NUM_WIN = NUM_WIN_DEF,
  parameter int CNT_W   = cnt_w(NUM_WIN)
) (
  input  logic [NUM_WIN-1:0][DATA_W-1:0] tbl_dat,
  input  logic [CNT_W-1:0]               win,
  output logic [DATA_W-1:0]              dat
);

  always_comb begin
    dat = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (win == CNT_W'(i)) dat = tbl_dat[i];
    end
  end

endmodule

// File: rtl/xpb_accum_seq.sv
// Walks NUM_WIN 5-bit windows one per cycle, adding each xpb residue onto the lower part.
// Result valid NUM_WIN cycles after accept; held in DONE until out_ready, no input taken meanwhile.
`timescale 1ns/1ps
module xpb_accum_seq
  import xpb_accum_seq_pkg::*;
#(
  parameter int NUM_WIN = NUM_WIN_DEF,
  parameter int GUARD   = GUARD_DEF
) (
  input logic           clk,
  input logic           rst_n,
  xpb_accum_seq_if.slave bus
);

  localparam int CNT_W = cnt_w(NUM_WIN);
  localparam int ACC_W = DATA_W + GUARD;
  localparam int UPR_W = NUM_WIN * WIN_BITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WIN - 1);

  // NUM_WIN table values plus the lower part must never carry out of the guard bits.
  if (NUM_WIN + 1 > (1 << GUARD)) begin : g_guard_check
    $error("xpb_accum_seq: GUARD too small for NUM_WIN");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [UPR_W-1:0] upper_sr_q, upper_sr_d;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    upper_sr_d = upper_sr_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          upper_sr_d = bus.in_upper;
          acc_d      = {{GUARD{1'b0}}, bus.in_lower};
          cnt_d      = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        acc_d      = acc_q + {{GUARD{1'b0}}, bus.xpb_data};
        upper_sr_d = upper_sr_q >> WIN_BITS;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // out_sum shows the accumulator only while a result is being offered.
    out_sum_d = (state_d == DONE) ? acc_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      upper_sr_q <= '0;
      out_sum_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      upper_sr_q <= upper_sr_d;
      out_sum_q  <= out_sum_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ACCUM) || (state_q == DONE);
  assign bus.xpb_win   = (state_q == ACCUM) ? cnt_q : '0;
  assign bus.xpb_sel   = (state_q == ACCUM) ? upper_sr_q[WIN_BITS-1:0] : '0;
  assign bus.out_sum   = out_sum_q;

endmodule

// File: tb/tb_xpb_accum_seq.sv
// Bench for xpb_accum_seq: modelled xpb tables through xpb_win_mux, expected sums queued at accept.
`timescale 1ns/1ps
module tb_xpb_accum_seq;
  import xpb_accum_seq_pkg::*;

  localparam int NUM_WIN = NUM_WIN_DEF;
  localparam int GUARD   = GUARD_DEF;
  localparam int CNT_W   = cnt_w(NUM_WIN);
  localparam int ACC_W   = DATA_W + GUARD;
  localparam int UPR_W   = NUM_WIN * WIN_BITS;
  localparam logic [DATA_W-1:0] T01 = {32'h17f946a5, {30{32'h5a5a0f0f}}, 32'h11d914cc};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xpb_accum_seq_if #(.NUM_WIN(NUM_WIN), .GUARD(GUARD)) xif ();

  xpb_accum_seq #(.NUM_WIN(NUM_WIN), .GUARD(GUARD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (xif)
  );

  int   checks   = 0;
  int   failures = 0;
  bit   tbl_ones = 1'b0;
  logic [ACC_W-1:0] exp_q[$];
  logic [NUM_WIN-1:0][DATA_W-1:0] tbl_dat;

  // Table model: index 0 always yields 0, table 0 entry 1 is the reference residue.
  function automatic logic [DATA_W-1:0] tbl(input int k, input logic [WIN_BITS-1:0] idx,
                                             input bit ones);
    logic [DATA_W-1:0] v;
    logic [31:0] w;
    if (idx == '0) return '0;
    if (ones) return '1;
    if (k == 0 && idx == 5'd1) return T01;
    for (int j = 0; j < DATA_W / 32; j++) begin
      w = 32'h9e3779b9 * 32'(k * 32 + int'(idx) + j * 7 + 1);
      w = w ^ (w >> 15);
      v[j*32 +: 32] = w;
    end
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] model(input logic [UPR_W-1:0] upper,
                                             input logic [DATA_W-1:0] lower, input bit ones);
    logic [ACC_W-1:0] s;
    s = {{GUARD{1'b0}}, lower};
    for (int k = 0; k < NUM_WIN; k++)
      s = s + {{GUARD{1'b0}}, tbl(k, upper[k*WIN_BITS +: WIN_BITS], ones)};
    return s;
  endfunction

  function automatic int first_diff(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    for (int j = 0; j < 33; j++)
      if (a[j*32 +: 32] !== b[j*32 +: 32]) return j;
    return 0;
  endfunction

  function automatic logic [31:0] word_of(input logic [ACC_W-1:0] a, input int j);
    logic [1055:0] p;
    p = {{(1056-ACC_W){1'b0}}, a};
    return p[j*32 +: 32];
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_WIN; k++) tbl_dat[k] = tbl(k, xif.xpb_sel, tbl_ones);
  end

  xpb_win_mux #(.NUM_WIN(NUM_WIN), .CNT_W(CNT_W)) u_mux (
    .tbl_dat(tbl_dat),
    .win    (xif.xpb_win),
    .dat    (xif.xpb_data)
  );

  // Runs one operand end to end starting from a negedge; returns captured sum and accept time.
  task automatic do_op(input logic [UPR_W-1:0] upper, input logic [DATA_W-1:0] lower,
                       input int hold, input bit pulse_in,
                       output logic [ACC_W-1:0] got, output time t_acc);
    int n;
    int d;
    logic [ACC_W-1:0] held;
    n = 0;
    while (xif.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (xif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait in_ready=%b required 1", xif.in_ready);
    end
    xif.in_valid  = 1'b1;
    xif.in_upper  = upper;
    xif.in_lower  = lower;
    xif.out_ready = 1'b0;
    exp_q.push_back(model(upper, lower, tbl_ones));
    @(posedge clk);
    t_acc = $time;
    for (int k = 0; k < NUM_WIN; k++) begin
      @(negedge clk);
      if (k == 0) begin
        xif.in_valid = 1'b0;
        xif.in_upper = ~upper;
        xif.in_lower = ~lower;
      end
      checks++;
      if (xif.xpb_win !== CNT_W'(k) || xif.xpb_sel !== upper[k*WIN_BITS +: WIN_BITS] ||
          xif.out_valid !== 1'b0 || xif.in_ready !== 1'b0 || xif.busy !== 1'b1) begin
        failures++;
        $display("FAIL accum_cycle%0d win=%0d sel=%0d ov=%b ir=%b busy=%b required win=%0d sel=%0d ov=0 ir=0 busy=1",
                 k, xif.xpb_win, xif.xpb_sel, xif.out_valid, xif.in_ready, xif.busy,
                 k, upper[k*WIN_BITS +: WIN_BITS]);
      end
    end
    @(negedge clk);
    checks++;
    if (xif.out_valid !== 1'b1 || xif.busy !== 1'b1) begin
      failures++;
      $display("FAIL latency out_valid=%b busy=%b required 1 1 at accept+%0d", xif.out_valid,
               xif.busy, NUM_WIN);
    end
    checks++;
    if (exp_q.size() == 0 || xif.out_sum !== exp_q[0]) begin
      failures++;
      d = first_diff(xif.out_sum, exp_q[0]);
      $display("FAIL sum word%0d got=%h required=%h", d, word_of(xif.out_sum, d),
               word_of(exp_q[0], d));
    end
    got  = xif.out_sum;
    held = xif.out_sum;
    for (int h = 0; h < hold; h++) begin
      if (pulse_in) xif.in_valid = h[0];
      @(negedge clk);
      checks++;
      if (xif.out_valid !== 1'b1 || xif.in_ready !== 1'b0 || xif.out_sum !== held) begin
        failures++;
        $display("FAIL hold%0d out_valid=%b in_ready=%b sum_stable=%b required 1 0 1", h,
                 xif.out_valid, xif.in_ready, xif.out_sum === held);
      end
    end
    xif.in_valid  = 1'b0;
    xif.out_ready = 1'b1;
    @(negedge clk);
    xif.out_ready = 1'b0;
    checks++;
    if (xif.in_ready !== 1'b1 || xif.out_valid !== 1'b0 || xif.busy !== 1'b0 ||
        xif.out_sum !== '0) begin
      failures++;
      $display("FAIL release in_ready=%b out_valid=%b busy=%b sum_zero=%b required 1 0 0 1",
               xif.in_ready, xif.out_valid, xif.busy, xif.out_sum === '0);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    xif.in_valid  = 1'b0;
    xif.in_upper  = '0;
    xif.in_lower  = '0;
    xif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (xif.in_ready !== 1'b1 || xif.out_valid !== 1'b0 || xif.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl in_ready=%b out_valid=%b busy=%b required 1 0 0",
               xif.in_ready, xif.out_valid, xif.busy);
    end
    checks++;
    if (xif.out_sum !== '0 || xif.xpb_sel !== '0 || xif.xpb_win !== '0) begin
      failures++;
      $display("FAIL reset_dat sum_zero=%b sel=%0d win=%0d required 1 0 0",
               xif.out_sum === '0, xif.xpb_sel, xif.xpb_win);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (xif.in_ready !== 1'b1 || xif.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle in_ready=%b busy=%b required 1 0", xif.in_ready, xif.busy);
    end
  endtask

  task automatic test_all_zero();
    logic [ACC_W-1:0] got;
    time t;
    tbl_ones = 1'b0;
    do_op('0, DATA_W'(16'h1234), 0, 1'b0, got, t);
    checks++;
    if (got !== ACC_W'(16'h1234)) begin
      failures++;
      $display("FAIL all_zero got_low=%h required 1234", got[63:0]);
    end
  endtask

  task automatic test_single_window();
    logic [ACC_W-1:0] got;
    time t;
    tbl_ones = 1'b0;
    do_op(UPR_W'(1), '0, 0, 1'b0, got, t);
    checks++;
    if (got !== {{GUARD{1'b0}}, T01}) begin
      failures++;
      $display("FAIL single_window top=%h low=%h required top=017f946a5 low=11d914cc",
               got[ACC_W-1 -: 36], got[31:0]);
    end
  endtask

  task automatic test_full_scale();
    logic [ACC_W-1:0] got;
    time t;
    tbl_ones = 1'b1;
    do_op('1, '1, 0, 1'b0, got, t);
    checks++;
    if (got[ACC_W-1 -: GUARD] !== 4'h8 || got[DATA_W-1:0] !== ~DATA_W'(8)) begin
      failures++;
      $display("FAIL full_scale guard=%h low=%h required guard=8 low=fffffff7",
               got[ACC_W-1 -: GUARD], got[31:0]);
    end
    tbl_ones = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] got;
    time t;
    do_op(UPR_W'(40'h93_a5c1_7e42), {32{32'hc3a5_0f1e}}, 5, 1'b1, got, t);
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] got;
    logic [63:0] r;
    logic [DATA_W-1:0] lo;
    time t;
    for (int i = 0; i < 4; i++) begin
      r = {$urandom(), $urandom()};
      for (int j = 0; j < DATA_W / 32; j++) lo[j*32 +: 32] = $urandom();
      do_op(r[UPR_W-1:0], lo, i, 1'b0, got, t);
    end
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] got;
    time t1, t2;
    do_op(UPR_W'(40'h12_3456_789a), {32{32'h0badf00d}}, 0, 1'b0, got, t1);
    do_op(UPR_W'(40'hfe_dcba_9876), {32{32'h1357_9bdf}}, 0, 1'b0, got, t2);
    checks++;
    if (t2 - t1 !== time'((NUM_WIN + 2) * 10)) begin
      failures++;
      $display("FAIL throughput spacing=%0t required %0d", t2 - t1, (NUM_WIN + 2) * 10);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [ACC_W-1:0] got;
    time t;
    bit saw_valid;
    xif.in_valid = 1'b1;
    xif.in_upper = UPR_W'(40'hff_ffff_ffff);
    xif.in_lower = '1;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      xif.in_valid = 1'b0;
    end
    checks++;
    if (xif.xpb_win !== CNT_W'(3)) begin
      failures++;
      $display("FAIL abort_point win=%0d required 3", xif.xpb_win);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (xif.in_ready !== 1'b1 || xif.out_valid !== 1'b0 || xif.busy !== 1'b0 ||
        xif.out_sum !== '0 || xif.xpb_win !== '0) begin
      failures++;
      $display("FAIL abort in_ready=%b out_valid=%b busy=%b win=%0d required 1 0 0 0",
               xif.in_ready, xif.out_valid, xif.busy, xif.xpb_win);
    end
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (xif.out_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("FAIL abort_no_valid saw_out_valid=1 required 0");
    end
    do_op(UPR_W'(40'h00_0000_0021), DATA_W'(32'h55), 0, 1'b0, got, t);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_window();
    test_full_scale();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
